// File: rtl/bus_arbiter.sv
// Two-requester (code/data) arbiter for the single external bus port.
// Define W80386_BUS_ARBITER_RR_EN for round-robin; default is data priority with a starvation counter.
module bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        i_code_vaild,
    input  logic [31:0] i_code_address,
    output logic        o_code_ready,
    output logic [31:0] o_code_data_read,

    input  logic        i_data_vaild,
    input  logic        i_data_write_enable,
    input  logic [31:0] i_data_address,
    input  logic [31:0] i_data_data_write,
    output logic        o_data_ready,
    output logic [31:0] o_data_data_read,

    output logic        o_bus_vaild,
    input  logic        i_bus_ready,
    input  logic        i_bus_busy,
    output logic        o_bus_write_enable,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_data_read,
    output logic [31:0] o_bus_data_write,

    output logic        o_grant_code
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBus  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        grant_code_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] code_rdata_q;
    logic [31:0] data_rdata_q;

    logic        req_any;
    logic        start;
    logic        win_code;
    logic        capture;

    assign req_any = i_code_vaild | i_data_vaild;
    assign start   = (state_q == StIdle) && req_any && !i_bus_busy;
    assign capture = (state_q == StBus) && i_bus_ready;

`ifdef W80386_BUS_ARBITER_RR_EN
    // Preferred requester: 1 = code, 0 = data.
    logic rr_q;

    always_comb begin
        win_code = i_code_vaild && (!i_data_vaild || rr_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (start) begin
            rr_q <= !rr_q;
        end
    end
`else
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic       starve_hit;

    assign starve_hit = (starve_q == StarveMax);

    always_comb begin
        win_code = i_code_vaild && (!i_data_vaild || starve_hit);
    end

    // Count only data grants that made a pending code request wait.
    always_comb begin
        starve_d = starve_q;
        if (start) begin
            if (!win_code && i_code_vaild) begin
                starve_d = starve_q + 4'd1;
            end else begin
                starve_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = StBus;
            StBus:  if (i_bus_ready) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_code_q <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            code_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (start) begin
                grant_code_q <= win_code;
                // Code fetches are always reads.
                bus_we_q     <= win_code ? 1'b0 : i_data_write_enable;
                bus_addr_q   <= win_code ? i_code_address : i_data_address;
                bus_wdata_q  <= win_code ? 32'd0 : i_data_data_write;
            end
            if (capture) begin
                if (grant_code_q) begin
                    code_rdata_q <= i_bus_data_read;
                end else begin
                    data_rdata_q <= i_bus_data_read;
                end
            end
        end
    end

    always_comb begin
        o_bus_vaild        = (state_q == StBus);
        o_code_ready       = (state_q == StResp) && grant_code_q;
        o_data_ready       = (state_q == StResp) && !grant_code_q;
        o_bus_write_enable = bus_we_q;
        o_bus_address      = bus_addr_q;
        o_bus_data_write   = bus_wdata_q;
        o_code_data_read   = code_rdata_q;
        o_data_data_read   = data_rdata_q;
        o_grant_code       = grant_code_q;
    end

endmodule
